// File: rtl/msg_serializer.sv
// msg_serializer: splits MSG_W-bit messages into KEY_W-bit chunks with valid/ready on both sides.
// MSG_SERIALIZER_LSB_FIRST_EN selects LSB-chunk-first order; MSB-chunk-first otherwise.
module msg_serializer #(
    parameter int MSG_W = 64,
    parameter int KEY_W = 8,
    localparam int N_CHK = MSG_W / KEY_W,
    localparam int IDX_W = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_chunk,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);
    if (KEY_W < 1 || KEY_W > MSG_W || (MSG_W % KEY_W) != 0) begin : g_bad_params
        $error("msg_serializer: MSG_W must be a positive multiple of KEY_W");
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nx;
    logic [MSG_W-1:0] shift_reg, shift_nx, shifted;
    logic [IDX_W-1:0] idx, idx_nx;
    logic             last, fire, load;

`ifdef MSG_SERIALIZER_LSB_FIRST_EN
    assign out_chunk = shift_reg[KEY_W-1:0];
    assign shifted   = shift_reg >> KEY_W;
`else
    assign out_chunk = shift_reg[MSG_W-1 -: KEY_W];
    assign shifted   = shift_reg << KEY_W;
`endif

    assign out_valid = state == SHIFT;
    assign busy      = out_valid;
    assign out_idx   = idx;
    assign last      = idx == IDX_W'(N_CHK - 1);
    assign out_last  = last & out_valid;
    assign fire      = out_valid & out_ready;
    // Accepting the last chunk frees the register, so a new message can land in the same edge.
    assign in_ready  = !rst & ((state == IDLE) | (fire & last));
    assign load      = in_valid & in_ready;

    always_comb begin
        state_nx = load ? SHIFT : (fire & last) ? IDLE : state;
        shift_nx = load ? in_msg : fire ? shifted : shift_reg;
        idx_nx   = (load | (fire & last)) ? '0 : fire ? idx + IDX_W'(1) : idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            idx       <= '0;
        end else begin
            state     <= state_nx;
            shift_reg <= shift_nx;
            idx       <= idx_nx;
        end
    end
endmodule

// File: tb/tb_msg_serializer.sv
// tb_msg_serializer: directed checks of msg_serializer (32/8 main instance, 32/32 single-chunk instance).
module tb_msg_serializer;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, out_ready = 1;
    logic [31:0] in_msg = 0;
    logic        in_ready, out_valid, out_last, busy;
    logic [7:0]  out_chunk;
    logic [1:0]  out_idx;

    logic        b_in_valid = 0, b_out_ready = 1;
    logic [31:0] b_in_msg = 0;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [31:0] b_out_chunk;
    logic [0:0]  b_out_idx;

    int    total = 0, bad = 0;
    string step = "reset";

    always #5 clk = ~clk;

    msg_serializer #(.MSG_W(32), .KEY_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .out_valid(out_valid), .out_ready(out_ready), .out_chunk(out_chunk),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    msg_serializer #(.MSG_W(32), .KEY_W(32)) u_one (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_msg(b_in_msg),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_chunk(b_out_chunk),
        .out_idx(b_out_idx), .out_last(b_out_last), .busy(b_busy)
    );

    function automatic logic [7:0] ch(input logic [31:0] m, input int i);
`ifdef MSG_SERIALIZER_LSB_FIRST_EN
        return m[8*i +: 8];
`else
        return m[31-8*i -: 8];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] m, input int i, input logic rdy);
        chk($sformatf("valid%0d", i), 32'(out_valid), 1);
        chk($sformatf("chunk%0d", i), 32'(out_chunk), 32'(ch(m, i)));
        chk($sformatf("idx%0d", i), 32'(out_idx), 32'(i));
        chk($sformatf("last%0d", i), 32'(out_last), 32'(i == 3));
        chk($sformatf("in_ready%0d", i), 32'(in_ready), 32'(rdy));
    endtask

    task automatic idle_chk();
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_idx", 32'(out_idx), 0);
    endtask

    initial begin
        @(negedge clk);
        chk("valid", 32'(out_valid), 0);
        chk("busy", 32'(busy), 0);
        chk("chunk", 32'(out_chunk), 0);
        chk("idx", 32'(out_idx), 0);
        chk("last", 32'(out_last), 0);
        chk("in_ready_in_rst", 32'(in_ready), 0);
        chk("b_valid", 32'(b_out_valid), 0);
        rst = 0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 1);
        chk("b_in_ready_after_rst", 32'(b_in_ready), 1);

        step = "t1_stream";
        in_valid = 1; in_msg = 32'hDEADBEEF;
        @(negedge clk);
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            beat(32'hDEADBEEF, i, i == 3);
            @(negedge clk);
        end
        idle_chk();

        step = "t2_stall";
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        beat(32'hDEADBEEF, 0, 0);
        @(negedge clk);
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            beat(32'hDEADBEEF, 1, 0);
            @(negedge clk);
        end
        out_ready = 1;
        for (int i = 1; i < 4; i++) begin
            beat(32'hDEADBEEF, i, i == 3);
            @(negedge clk);
        end
        idle_chk();

        step = "t3_b2b";
        in_valid = 1; in_msg = 32'h11223344;
        @(negedge clk);
        in_msg = 32'h55667788;
        for (int i = 0; i < 4; i++) begin
            beat(32'h11223344, i, i == 3);
            @(negedge clk);
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            beat(32'h55667788, i, i == 3);
            @(negedge clk);
        end
        idle_chk();

        step = "t4_ignore";
        in_valid = 1; in_msg = 32'h01020304;
        @(negedge clk);
        in_valid = 0;
        beat(32'h01020304, 0, 0);
        @(negedge clk);
        in_valid = 1; in_msg = 32'hFFFFFFFF;
        for (int i = 1; i < 4; i++) begin
            beat(32'h01020304, i, i == 3);
            @(negedge clk);
        end
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            beat(32'hFFFFFFFF, i, i == 3);
            @(negedge clk);
        end
        idle_chk();

        step = "t5_midrst";
        in_valid = 1; in_msg = 32'hCAFEBABE;
        @(negedge clk);
        in_valid = 0;
        beat(32'hCAFEBABE, 0, 0);
        @(negedge clk);
        beat(32'hCAFEBABE, 1, 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        idle_chk();
        chk("rst_chunk", 32'(out_chunk), 0);
        chk("rst_last", 32'(out_last), 0);
        in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            beat(32'hCAFEBABE, i, i == 3);
            @(negedge clk);
        end
        idle_chk();

        step = "t6_single";
        b_in_valid = 1; b_in_msg = 32'hA5A50F0F;
        @(negedge clk);
        b_in_msg = 32'h12345678;
        chk("b_valid0", 32'(b_out_valid), 1);
        chk("b_chunk0", b_out_chunk, 32'hA5A50F0F);
        chk("b_idx0", 32'(b_out_idx), 0);
        chk("b_last0", 32'(b_out_last), 1);
        chk("b_in_ready0", 32'(b_in_ready), 1);
        @(negedge clk);
        b_in_valid = 0;
        chk("b_valid1", 32'(b_out_valid), 1);
        chk("b_chunk1", b_out_chunk, 32'h12345678);
        chk("b_last1", 32'(b_out_last), 1);
        @(negedge clk);
        chk("b_valid_end", 32'(b_out_valid), 0);
        chk("b_busy_end", 32'(b_busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
